axis_frame_len_sched: RTL
=========================

# axis_frame_len_sched

Shared AXI4-Stream frame-length measurement engine, time-multiplexed across PORTS passively monitored streams. A round-robin scheduler grants one port at a time, aligns to that port's next frame boundary, measures one whole frame in words (tkeep-weighted), and reports the length tagged with the port index over a valid/ready status stream. It sits beside the datapath as a low-cost statistics tap, replacing PORTS separate length counters.

## Interface
- PORTS, 4: number of monitored streams (1–16)
- DATA_WIDTH, 64: monitored tdata width in bits
- KEEP_ENABLE, (DATA_WIDTH>8): tkeep is meaningful; if 0, every beat counts 1
- KEEP_WIDTH, (DATA_WIDTH/8): tkeep width per port
- LEN_WIDTH, 16: length counter and report width
- ID_WIDTH, $clog2(PORTS) (min 1): port-index width

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- monitor_axis_tkeep  in  PORTS*KEEP_WIDTH  port p at [p*KEEP_WIDTH +: KEEP_WIDTH]
- monitor_axis_tvalid  in  PORTS  per-port tvalid
- monitor_axis_tready  in  PORTS  per-port tready
- monitor_axis_tlast  in  PORTS  per-port tlast
- enable  in  1  scheduler run enable
- port_mask  in  PORTS  1 = port eligible for scheduling
- m_axis_len_tdata  out  LEN_WIDTH  measured frame length
- m_axis_len_tid  out  ID_WIDTH  port index of measurement
- m_axis_len_tuser  out  1  1 = length saturated
- m_axis_len_tvalid  out  1  report valid
- m_axis_len_tready  in  1  report accepted
- busy  out  1  state != IDLE

## Operation
- Transfer on port p: tvalid[p] & tready[p].
- Per-port in_frame[p], always tracked for all ports: set on non-last transfer, cleared on last transfer; reset 0.
- Beat weight: popcount(tkeep[p]) when KEEP_ENABLE, else 1.
- FSM states: IDLE, ARB, SYNC, MEASURE, REPORT.
- IDLE: enable=1 → ARB.
- ARB (one cycle): enable=0 → IDLE; (port_mask==0) → stay; else grant first set mask bit at or after rr_ptr (wrapping), sel <= p, rr_ptr <= p+1 mod PORTS, len <= 0, sat <= 0; next MEASURE if in_frame_next[p]==0, else SYNC.
- SYNC: wait for tlast transfer on sel → MEASURE (that beat not counted). enable=0 or port_mask[sel]=0 → IDLE/ARB respectively.
- MEASURE: each transfer on sel adds weight; sum > 2^LEN_WIDTH-1 saturates at all-ones and sets sat. On tlast transfer: tdata <= final sum (including that beat), tid <= sel, tuser <= sat → REPORT. enable and port_mask ignored in MEASURE (frame always completes).
- REPORT: tvalid=1, outputs stable until tready; on handshake → ARB (or IDLE if enable=0).
- Traffic on non-selected ports only updates in_frame; never counted.
- Reset mid-operation: all state cleared immediately; in-flight measurement discarded, no report.

## Timing
- Reset values: tdata=0, tid=0, tuser=0, tvalid=0, busy=0; rr_ptr=0, state IDLE, in_frame=0.
- enable rises cycle E → ARB at E+1 → SYNC/MEASURE at E+2; MEASURE counts transfers from E+2 on.
- tlast transfer in cycle T → tvalid=1 at T+1.
- Handshake at H → ARB at H+1 → next measurement state at H+2; frames starting at H+1 are caught only via in_frame_next in ARB.
- Single-beat frame (tlast on first beat) in MEASURE: valid report, length = that beat's weight.
- tvalid never drops without tready; no report ever overwritten.

## Structure
- Shared package: state encoding (IDLE, ARB, SYNC, MEASURE, REPORT) and popcount function.
- One sub-module: axis_frame_len_rr_arb (PORTS-wide masked round-robin, combinational grant plus registered pointer).
- Top holds FSM, in_frame vector, port mux, accumulator and report register.

## Test plan
- Reset, enable=1, mask=4'b0001, port 0 sends 3 beats tkeep=8'hFF then tlast tkeep=8'h0F → report tdata=28, tid=0, tuser=0, tvalid one cycle after tlast.
- Mask=4'b1111, every port sends back-to-back 2-beat full frames → reports tid 0,1,2,3,0 in order, tdata=16 each.
- Grant port 2 while mid-frame (in_frame=1) → that frame ignored, next full frame measured; tdata equals next frame only.
- LEN_WIDTH=8, 40 beats tkeep=8'hFF → tdata=8'hFF, tuser=1.
- Hold m_axis_len_tready=0 10 cycles during REPORT → tdata/tid/tuser/tvalid stable; ports' frames during stall not reported; after accept grant advances.
- Assert rst during MEASURE → outputs at reset values next cycle, no report; mask=0 with enable=1 → stays ARB, busy=1, no tvalid.

Source files
------------

// File: rtl/axis_frame_len_sched_pkg.sv
// Shared definitions for the frame-length scheduler: FSM encoding and tkeep popcount.
package axis_frame_len_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARB     = 3'd1,
        ST_SYNC    = 3'd2,
        ST_MEASURE = 3'd3,
        ST_REPORT  = 3'd4
    } state_t;

    // Callers zero-extend narrower keep vectors into the 256-bit argument.
    function automatic logic [8:0] popcount(input logic [255:0] v);
        logic [8:0] c;
        c = '0;
        for (int i = 0; i < 256; i++) c = c + 9'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/axis_frame_len_rr_arb.sv
// Masked round-robin arbiter: combinational grant, pointer moves past the winner on advance.
module axis_frame_len_rr_arb #(
    parameter int PORTS    = 4,
    parameter int ID_WIDTH = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PORTS-1:0]    i_mask,
    input  logic                i_advance,
    output logic [ID_WIDTH-1:0] o_grant,
    output logic                o_valid
);

    logic [ID_WIDTH-1:0] r_ptr;
    logic [ID_WIDTH-1:0] w_grant;
    logic                w_valid;

    // Scan from the highest offset down so the nearest eligible port at/after r_ptr wins.
    always_comb begin
        int unsigned idx;
        w_grant = '0;
        w_valid = 1'b0;
        idx     = 0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            idx = (int'(r_ptr) + i) % PORTS;
            if (i_mask[idx]) begin
                w_grant = ID_WIDTH'(idx);
                w_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_ptr <= '0;
        else if (i_advance)
            r_ptr <= (int'(w_grant) == PORTS - 1) ? '0 : w_grant + 1'b1;
    end

    assign o_grant = w_grant;
    assign o_valid = w_valid;

endmodule

// File: rtl/axis_frame_len_sched.sv
// Shared frame-length tap: round-robin picks a monitored port, aligns to a frame start, measures it.
module axis_frame_len_sched
    import axis_frame_len_sched_pkg::*;
#(
    parameter int PORTS       = 4,
    parameter int DATA_WIDTH  = 64,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
    parameter int LEN_WIDTH   = 16,
    parameter int ID_WIDTH    = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS*KEEP_WIDTH-1:0] monitor_axis_tkeep,
    input  logic [PORTS-1:0]            monitor_axis_tvalid,
    input  logic [PORTS-1:0]            monitor_axis_tready,
    input  logic [PORTS-1:0]            monitor_axis_tlast,
    input  logic                        enable,
    input  logic [PORTS-1:0]            port_mask,
    output logic [LEN_WIDTH-1:0]        m_axis_len_tdata,
    output logic [ID_WIDTH-1:0]         m_axis_len_tid,
    output logic                        m_axis_len_tuser,
    output logic                        m_axis_len_tvalid,
    input  logic                        m_axis_len_tready,
    output logic                        busy
);

    localparam int SUMW = LEN_WIDTH + 9;

    state_t                r_state;
    logic [PORTS-1:0]      r_in_frame;
    logic [ID_WIDTH-1:0]   r_sel;
    logic [LEN_WIDTH-1:0]  r_len;
    logic                  r_sat;
    logic [LEN_WIDTH-1:0]  r_tdata;
    logic [ID_WIDTH-1:0]   r_tid;
    logic                  r_tuser;
    logic                  r_tvalid;

    logic [PORTS-1:0]      w_xfer;
    logic [PORTS-1:0]      w_in_frame_next;
    logic [KEEP_WIDTH-1:0] w_keep;
    logic [8:0]            w_weight;
    logic [SUMW-1:0]       w_sum;
    logic                  w_ovf;
    logic [LEN_WIDTH-1:0]  w_len_next;
    logic                  w_sel_xfer;
    logic                  w_sel_last;
    logic [ID_WIDTH-1:0]   w_grant;
    logic                  w_grant_vld;
    logic                  w_arb_adv;

    assign w_xfer          = monitor_axis_tvalid & monitor_axis_tready;
    assign w_in_frame_next = (r_in_frame & ~w_xfer) | (w_xfer & ~monitor_axis_tlast);

    always_ff @(posedge clk) begin
        if (rst) r_in_frame <= '0;
        else     r_in_frame <= w_in_frame_next;
    end

    assign w_keep     = monitor_axis_tkeep[int'(r_sel)*KEEP_WIDTH +: KEEP_WIDTH];
    assign w_weight   = KEEP_ENABLE ? popcount(256'(w_keep)) : 9'd1;
    assign w_sum      = SUMW'(r_len) + SUMW'(w_weight);
    assign w_ovf      = w_sum > SUMW'({LEN_WIDTH{1'b1}});
    assign w_len_next = w_ovf ? '1 : w_sum[LEN_WIDTH-1:0];
    assign w_sel_xfer = w_xfer[r_sel];
    assign w_sel_last = monitor_axis_tlast[r_sel];
    assign w_arb_adv  = (r_state == ST_ARB) && enable && w_grant_vld;

    axis_frame_len_rr_arb #(
        .PORTS    (PORTS),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_mask    (port_mask),
        .i_advance (w_arb_adv),
        .o_grant   (w_grant),
        .o_valid   (w_grant_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_sel    <= '0;
            r_len    <= '0;
            r_sat    <= 1'b0;
            r_tdata  <= '0;
            r_tid    <= '0;
            r_tuser  <= 1'b0;
            r_tvalid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (enable) r_state <= ST_ARB;
                ST_ARB: begin
                    if (!enable)
                        r_state <= ST_IDLE;
                    else if (w_grant_vld) begin
                        r_sel   <= w_grant;
                        r_len   <= '0;
                        r_sat   <= 1'b0;
                        // A frame already open (or opening this cycle) must be skipped.
                        r_state <= w_in_frame_next[w_grant] ? ST_SYNC : ST_MEASURE;
                    end
                end
                ST_SYNC: begin
                    if (!enable)
                        r_state <= ST_IDLE;
                    else if (!port_mask[r_sel])
                        r_state <= ST_ARB;
                    else if (w_sel_xfer && w_sel_last)
                        r_state <= ST_MEASURE;
                end
                ST_MEASURE: begin
                    if (w_sel_xfer) begin
                        r_len <= w_len_next;
                        r_sat <= r_sat | w_ovf;
                        if (w_sel_last) begin
                            r_tdata  <= w_len_next;
                            r_tid    <= r_sel;
                            r_tuser  <= r_sat | w_ovf;
                            r_tvalid <= 1'b1;
                            r_state  <= ST_REPORT;
                        end
                    end
                end
                ST_REPORT: begin
                    if (m_axis_len_tready) begin
                        r_tvalid <= 1'b0;
                        r_state  <= enable ? ST_ARB : ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign m_axis_len_tdata  = r_tdata;
    assign m_axis_len_tid    = r_tid;
    assign m_axis_len_tuser  = r_tuser;
    assign m_axis_len_tvalid = r_tvalid;
    assign busy              = (r_state != ST_IDLE);

endmodule
